tblink_rpc_cmd_membridge: RTL and testbench
===========================================

TBLINK_RPC_CMD_MEMBRIDGE -- requirements
Module: tblink_rpc_cmd_membridge

Interface
REQ-001 SHALL have parameter CMD_IN_PARAMS_SZ, default 8: width of cmd_in_params, in bytes.
REQ-002 SHALL have parameter CMD_IN_RSP_SZ, default 8: width of cmd_in_rsp, in bytes; minimum 5.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for bus_ack.
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- uclock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- cmd_in  in  8  command code.
- cmd_in_sz  in  8  parameter byte count.
- cmd_in_params  in  CMD_IN_PARAMS_SZ*8  parameters, byte 0 in bits [7:0], little-endian.
- cmd_in_put_i  in  1  producer toggle index.
- cmd_in_get_i  out  1  consumer toggle index.
- cmd_in_rsp  out  CMD_IN_RSP_SZ*8  response bytes.
- cmd_in_rsp_sz  out  8  response byte count.
- bus_req  out  1  bus request.
- bus_we  out  1  1=write.
- bus_adr  out  32  bus address.
- bus_dat_w  out  32  write data.
- bus_dat_r  in  32  read data.
- bus_ack  in  1  single-cycle completion.

Function
REQ-005 A command SHALL be pending when cmd_in_put_i != cmd_in_get_i; cmd_in/sz/params are stable while pending.
REQ-006 FSM states SHALL be IDLE, EXEC, BUS, RESP.
REQ-007 IDLE with command pending SHALL latch cmd_in, cmd_in_sz and params, then go to EXEC next cycle.
REQ-008 IDLE with no command pending SHALL remain in IDLE.
REQ-009 EXEC SHALL decode the latched command:
- 0x00 PING, sz 0: status OK, no bus access.
- 0x01 WRITE32, sz 8: adr = params bytes 0-3, data = bytes 4-7.
- 0x02 READ32, sz 4: adr = bytes 0-3.
REQ-010 In EXEC, a valid WRITE32/READ32 SHALL go to BUS; any other case SHALL go to RESP.
REQ-011 Status codes SHALL be: OK=0x00, BADCMD=0x01 (unknown code), BADSZ=0x02 (known code, wrong sz), TIMEOUT=0x03.
REQ-012 BUS: bus_req, bus_we, bus_adr and bus_dat_w SHALL be registered and held stable until ack or timeout.
REQ-013 BUS: a 32-bit wait counter SHALL be cleared on entry and increment each cycle.
REQ-014 bus_ack sampled high SHALL deassert bus_req next cycle, capture bus_dat_r for reads, and go to RESP.
REQ-015 A counter reaching TIMEOUT without ack SHALL deassert bus_req, set status TIMEOUT and go to RESP.
REQ-016 bus_ack outside BUS SHALL be ignored.
REQ-017 Ack and timeout in the same cycle SHALL be treated as ack.
REQ-018 RESP SHALL drive cmd_in_rsp byte 0 = status.
REQ-019 For READ32 OK, RESP SHALL drive bytes 1-4 = read data (LE) and cmd_in_rsp_sz = 5; otherwise cmd_in_rsp_sz = 1.
REQ-020 Unused cmd_in_rsp bytes SHALL be 0.
REQ-021 RESP SHALL toggle cmd_in_get_i in the same edge as the rsp/rsp_sz update, then go to IDLE.
REQ-022 rsp/rsp_sz SHALL hold until the next RESP.
REQ-023 Latency: pending seen in IDLE at cycle N -> PING/error get toggle visible at N+3.
REQ-024 Latency: bus_req high at N+2; ack at cycle M -> get toggle visible at M+2.
REQ-025 The toggle index SHALL wrap naturally; back-to-back commands SHALL incur no extra idle beyond one IDLE cycle.

Reset
REQ-026 Reset SHALL force IDLE, cmd_in_get_i=0, bus_req=0, bus_we=0, bus_adr=0, bus_dat_w=0, cmd_in_rsp=0, cmd_in_rsp_sz=0, counter=0.
REQ-027 Reset mid-BUS SHALL drop bus_req next cycle, produce no response, and not toggle get.

Verification
REQ-028 WRITE32 adr=0x1000 data=0xDEADBEEF, ack after 3 cycles -> one bus_req/we pulse with exact values; rsp byte0=0x00, rsp_sz=1, get toggled once.
REQ-029 READ32 adr=0x20, bus_dat_r=0x12345678 on ack -> rsp bytes = 00 78 56 34 12, rsp_sz=5.
REQ-030 READ32 with no ack, TIMEOUT=8 -> bus_req high 8 cycles then low; rsp byte0=0x03, rsp_sz=1.
REQ-031 Error and PING responses:
- cmd 0x7F -> status 0x01, no bus_req.
- cmd 0x01 with sz 4 -> status 0x02, no bus_req.
- PING -> status 0x00 at N+3.
REQ-032 Reset asserted 2 cycles into BUS -> bus_req 0 after next edge, get stays 0; subsequent PING completes normally.
REQ-033 Four back-to-back WRITE32s, put toggled immediately on each get -> four bus transactions in order, get index parity = 0 at end.

Source files
------------

// File: rtl/tblink_rpc_cmd_membridge.sv
// Command-to-bus bridge: decodes toggle-handshaked RPC commands (PING/WRITE32/READ32)
// into single 32-bit bus transactions and returns a status/data response.
module tblink_rpc_cmd_membridge #(
    parameter int CMD_IN_PARAMS_SZ = 8,
    parameter int CMD_IN_RSP_SZ    = 8,
    parameter int TIMEOUT          = 255
) (
    input  logic                          uclock,
    input  logic                          reset,
    input  logic [7:0]                    cmd_in,
    input  logic [7:0]                    cmd_in_sz,
    input  logic [CMD_IN_PARAMS_SZ*8-1:0] cmd_in_params,
    input  logic                          cmd_in_put_i,
    output logic                          cmd_in_get_i,
    output logic [CMD_IN_RSP_SZ*8-1:0]    cmd_in_rsp,
    output logic [7:0]                    cmd_in_rsp_sz,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [31:0]                   bus_adr,
    output logic [31:0]                   bus_dat_w,
    input  logic [31:0]                   bus_dat_r,
    input  logic                          bus_ack
);

    localparam int PW = CMD_IN_PARAMS_SZ * 8;
    localparam int PL = (PW > 64) ? PW : 64;
    localparam int RW = CMD_IN_RSP_SZ * 8;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BADCMD  = 8'h01;
    localparam logic [7:0] ST_BADSZ   = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    typedef enum logic [1:0] {IDLE, EXEC, BUS, RESP} state_t;

    state_t          state, state_next;
    logic [7:0]      cmd_q, sz_q, status_q;
    logic [PL-1:0]   params_q;
    logic [31:0]     rdata_q, wait_cnt;
    logic            is_read_q;

    logic            pending, timeout_hit;
    logic [7:0]      exec_status;
    logic            exec_bus, exec_we;
    logic [RW-1:0]   rsp_next;
    logic [7:0]      rsp_sz_next;

    assign pending     = (cmd_in_put_i != cmd_in_get_i);
    assign timeout_hit = ((wait_cnt + 32'd1) == 32'(TIMEOUT));

    always_comb begin
        exec_status = ST_BADCMD;
        exec_bus    = 1'b0;
        exec_we     = 1'b0;
        case (cmd_q)
            8'h00: exec_status = (sz_q == 8'd0) ? ST_OK : ST_BADSZ;
            8'h01: begin
                if (sz_q == 8'd8) begin
                    exec_status = ST_OK;
                    exec_bus    = 1'b1;
                    exec_we     = 1'b1;
                end else begin
                    exec_status = ST_BADSZ;
                end
            end
            8'h02: begin
                if (sz_q == 8'd4) begin
                    exec_status = ST_OK;
                    exec_bus    = 1'b1;
                end else begin
                    exec_status = ST_BADSZ;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_next      = '0;
        rsp_next[7:0] = status_q;
        rsp_sz_next   = 8'd1;
        if (is_read_q && status_q == ST_OK) begin
            rsp_next[39:8] = rdata_q;
            rsp_sz_next    = 8'd5;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pending) state_next = EXEC;
            EXEC: state_next = exec_bus ? BUS : RESP;
            BUS:  if (bus_ack || timeout_hit) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge uclock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge uclock) begin
        if (reset) begin
            cmd_q         <= '0;
            sz_q          <= '0;
            params_q      <= '0;
            status_q      <= '0;
            rdata_q       <= '0;
            is_read_q     <= 1'b0;
            wait_cnt      <= '0;
            cmd_in_get_i  <= 1'b0;
            cmd_in_rsp    <= '0;
            cmd_in_rsp_sz <= '0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_adr       <= '0;
            bus_dat_w     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        cmd_q    <= cmd_in;
                        sz_q     <= cmd_in_sz;
                        params_q <= PL'(cmd_in_params);
                    end
                end
                EXEC: begin
                    status_q  <= exec_status;
                    is_read_q <= exec_bus & ~exec_we;
                    wait_cnt  <= '0;
                    if (exec_bus) begin
                        bus_req   <= 1'b1;
                        bus_we    <= exec_we;
                        bus_adr   <= params_q[31:0];
                        bus_dat_w <= exec_we ? params_q[63:32] : '0;
                    end
                end
                BUS: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    // ack wins over a coincident timeout
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (is_read_q) rdata_q <= bus_dat_r;
                    end else if (timeout_hit) begin
                        bus_req  <= 1'b0;
                        bus_we   <= 1'b0;
                        status_q <= ST_TIMEOUT;
                    end
                end
                RESP: begin
                    cmd_in_get_i  <= ~cmd_in_get_i;
                    cmd_in_rsp    <= rsp_next;
                    cmd_in_rsp_sz <= rsp_sz_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tblink_rpc_cmd_membridge.sv
// Directed self-checking bench for tblink_rpc_cmd_membridge (TIMEOUT overridden to 8).
module tb_tblink_rpc_cmd_membridge;

    logic        uclock = 1'b0;
    logic        reset;
    logic [7:0]  cmd_in, cmd_in_sz;
    logic [63:0] cmd_in_params;
    logic        cmd_in_put_i;
    logic        cmd_in_get_i;
    logic [63:0] cmd_in_rsp;
    logic [7:0]  cmd_in_rsp_sz;
    logic        bus_req, bus_we;
    logic [31:0] bus_adr, bus_dat_w, bus_dat_r;
    logic        bus_ack;

    int pass_cnt = 0;
    int total    = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    tblink_rpc_cmd_membridge #(
        .CMD_IN_PARAMS_SZ(8),
        .CMD_IN_RSP_SZ(8),
        .TIMEOUT(8)
    ) dut (
        .uclock(uclock), .reset(reset),
        .cmd_in(cmd_in), .cmd_in_sz(cmd_in_sz), .cmd_in_params(cmd_in_params),
        .cmd_in_put_i(cmd_in_put_i), .cmd_in_get_i(cmd_in_get_i),
        .cmd_in_rsp(cmd_in_rsp), .cmd_in_rsp_sz(cmd_in_rsp_sz),
        .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr),
        .bus_dat_w(bus_dat_w), .bus_dat_r(bus_dat_r), .bus_ack(bus_ack)
    );

    always #5 uclock = ~uclock;

    always @(negedge uclock) begin
        if (bus_req && !req_prev) req_rises++;
        req_prev = bus_req;
    end

    task automatic step();
        @(posedge uclock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [7:0] c, input logic [7:0] s, input logic [63:0] p);
        cmd_in        = c;
        cmd_in_sz     = s;
        cmd_in_params = p;
        cmd_in_put_i  = ~cmd_in_put_i;
    endtask

    initial begin
        int r0, hc;
        logic g0;
        reset = 1'b1; cmd_in = '0; cmd_in_sz = '0; cmd_in_params = '0;
        cmd_in_put_i = 1'b0; bus_dat_r = '0; bus_ack = 1'b0;
        step(); step();
        check("rst_get", 64'(cmd_in_get_i), 64'd0);
        check("rst_req", 64'(bus_req), 64'd0);
        check("rst_adr", 64'(bus_adr), 64'd0);
        check("rst_rsp", cmd_in_rsp, 64'd0);
        check("rst_rspsz", 64'(cmd_in_rsp_sz), 64'd0);
        reset = 1'b0;
        step();

        // PING: toggle visible exactly 3 cycles after pending
        issue(8'h00, 8'd0, 64'd0);
        step(); step();
        check("ping_early", 64'(cmd_in_get_i), 64'd0);
        step();
        check("ping_get", 64'(cmd_in_get_i), 64'd1);
        check("ping_rsp", cmd_in_rsp, 64'd0);
        check("ping_rspsz", 64'(cmd_in_rsp_sz), 64'd1);

        // WRITE32 0x1000 <- 0xDEADBEEF, ack after 3 held cycles
        r0 = req_rises;
        issue(8'h01, 8'd8, 64'hDEADBEEF_00001000);
        step(); step();
        check("wr_req", 64'(bus_req), 64'd1);
        check("wr_we", 64'(bus_we), 64'd1);
        check("wr_adr", 64'(bus_adr), 64'h1000);
        check("wr_dat", 64'(bus_dat_w), 64'hDEADBEEF);
        step(); step(); step();
        check("wr_hold", {bus_req, bus_we, bus_adr, bus_dat_w}, {1'b1, 1'b1, 32'h1000, 32'hDEADBEEF});
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("wr_req_drop", 64'({bus_req, bus_we}), 64'd0);
        check("wr_get_wait", 64'(cmd_in_get_i), 64'd1);
        step();
        check("wr_get", 64'(cmd_in_get_i), 64'd0);
        check("wr_rsp", cmd_in_rsp, 64'd0);
        check("wr_rspsz", 64'(cmd_in_rsp_sz), 64'd1);
        check("wr_pulses", 64'(req_rises - r0), 64'd1);

        // READ32 0x20, immediate ack with data
        issue(8'h02, 8'd4, 64'h20);
        step(); step();
        check("rd_req", {bus_req, bus_we, bus_adr}, {1'b1, 1'b0, 32'h20});
        bus_ack = 1'b1; bus_dat_r = 32'h12345678;
        step();
        bus_ack = 1'b0; bus_dat_r = '0;
        step();
        check("rd_get", 64'(cmd_in_get_i), 64'd1);
        check("rd_rsp", cmd_in_rsp, 64'h00000012_34567800);
        check("rd_rspsz", 64'(cmd_in_rsp_sz), 64'd5);

        // READ32 with no ack: 8 cycles of bus_req then timeout status
        issue(8'h02, 8'd4, 64'h44);
        step(); step();
        hc = 0;
        while (bus_req && hc < 20) begin
            hc++;
            step();
        end
        check("to_cycles", 64'(hc), 64'd8);
        step();
        check("to_get", 64'(cmd_in_get_i), 64'd0);
        check("to_rsp", cmd_in_rsp, 64'h03);
        check("to_rspsz", 64'(cmd_in_rsp_sz), 64'd1);

        // unknown command and bad size: error status, no bus activity
        r0 = req_rises;
        issue(8'h7F, 8'd0, 64'd0);
        step(); step(); step();
        check("badcmd_get", 64'(cmd_in_get_i), 64'd1);
        check("badcmd_rsp", cmd_in_rsp, 64'h01);
        issue(8'h01, 8'd4, 64'h1234);
        step(); step(); step();
        check("badsz_get", 64'(cmd_in_get_i), 64'd0);
        check("badsz_rsp", cmd_in_rsp, 64'h02);
        check("badsz_rspsz", 64'(cmd_in_rsp_sz), 64'd1);
        check("err_no_req", 64'(req_rises - r0), 64'd0);

        // reset two cycles into BUS
        issue(8'h02, 8'd4, 64'h80);
        step(); step();
        check("mid_req", 64'(bus_req), 64'd1);
        step(); step();
        reset = 1'b1; cmd_in_put_i = 1'b0;
        step();
        check("mid_req_drop", 64'(bus_req), 64'd0);
        check("mid_get", 64'(cmd_in_get_i), 64'd0);
        reset = 1'b0;
        step(); step(); step(); step();
        check("mid_get_after", 64'(cmd_in_get_i), 64'd0);
        check("mid_rspsz", 64'(cmd_in_rsp_sz), 64'd0);
        issue(8'h00, 8'd0, 64'd0);
        step(); step(); step();
        check("post_ping_get", 64'(cmd_in_get_i), 64'd1);
        check("post_ping_rsp", {cmd_in_rsp, cmd_in_rsp_sz}, {64'd0, 8'd1});

        // four back-to-back writes from a fresh reset
        reset = 1'b1; cmd_in_put_i = 1'b0;
        step();
        reset = 1'b0;
        r0 = req_rises;
        for (int k = 0; k < 4; k++) begin
            issue(8'h01, 8'd8, {32'hA000_0000 + 32'(k), 32'h100 + 32'(4 * k)});
            for (int i = 0; i < 20 && !bus_req; i++) step();
            check("b2b_req", {bus_req, bus_adr, bus_dat_w},
                  {1'b1, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k)});
            bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
            g0 = cmd_in_get_i;
            for (int i = 0; i < 20 && cmd_in_get_i == g0; i++) step();
            check("b2b_get", 64'(cmd_in_get_i), 64'(cmd_in_put_i));
        end
        check("b2b_parity", 64'(cmd_in_get_i), 64'd0);
        check("b2b_pulses", 64'(req_rises - r0), 64'd4);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
